// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency 16-bit word memory responder with abort and hold handshake.
// Optional out-of-range detection on upper address bits is enabled by DATA_MEM_RESP_OOR_EN.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Data_en,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic        complete_data,
    output logic [15:0] Data_dout,
    output logic        oor_flag
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [15:0]         din_q, din_d;
    logic [15:0]         dout_q, dout_d;
    logic                oor_q, oor_d;
    logic                load, wr_en;
    logic [15:0]         mem [0:2**ADDR_W-1];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        din_d   = din_q;
        unique case (state_q)
            IDLE: if (Data_en) begin
                rd_d    = Data_rd;
                idx_d   = Data_addr[ADDR_W-1:0];
                din_d   = Data_din;
                cnt_d   = 4'(LATENCY - 1);
                state_d = LATENCY > 1 ? WAIT : DONE;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = !Data_en ? IDLE : (cnt_q == 4'd1 ? DONE : WAIT);
            end
            DONE:    state_d = Data_en ? HOLD : IDLE;
            default: state_d = Data_en ? HOLD : IDLE;
        endcase
    end
    // Read data is fetched on the edge entering DONE so it is valid alongside complete_data.
    assign load = state_d == DONE;
`ifdef DATA_MEM_RESP_OOR_EN
    logic upper_q, upper_d;
    assign upper_d = state_q == IDLE ? (32'(Data_addr) >> ADDR_W) != 32'd0 : upper_q;
    assign dout_d  = load && rd_d ? (upper_d ? 16'hDEAD : mem[idx_d]) : dout_q;
    assign oor_d   = oor_q | (load & upper_d);
    assign wr_en   = state_q == DONE && !rd_q && !upper_q && !reset;
    always_ff @(posedge clock)
        upper_q <= reset ? 1'b0 : upper_d;
`else
    logic unused_upper;
    assign unused_upper = ^Data_addr;
    assign dout_d = load && rd_d ? mem[idx_d] : dout_q;
    assign oor_d  = 1'b0;
    assign wr_en  = state_q == DONE && !rd_q && !reset;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            din_q   <= 16'h0000;
            dout_q  <= 16'h0000;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            oor_q   <= oor_d;
        end
    end
    always_ff @(posedge clock)
        if (wr_en) mem[idx_q] <= din_q;
    assign complete_data = state_q == DONE;
    assign Data_dout     = dout_q;
    assign oor_flag      = oor_q;
endmodule
